reaction_session_ctrl: RTL
==========================

# reaction_session_ctrl

- Multi-round session scheduler for the reaction game.
- Sequences the single-round game FSM through `ROUNDS` consecutive rounds by issuing one start pulse per round.
- Captures each round's result from the reaction-timer datapath and accumulates it. Reports best time and the truncated integer average of valid rounds.
- Drives the number shown on the seven-segment driver. Sits between the start button and the game FSM.

## Interface
Parameters:
- `ROUNDS`, 5, rounds per session; legal range 1..15.
- `HOLD_MS`, 2000, ms each round result stays on display before the next round starts; legal range 1..65535.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ms_tick`  in  1  one-cycle pulse every 1 ms.
- `session_btn`  in  1  one-cycle, debounced pulse; starts a session.
- `disp_sel`  in  1  DONE-state display select: 0 = average, 1 = best.
- `fsm_show_time`  in  1  game FSM level; high while a round result is valid.
- `fsm_early_error`  in  1  game FSM level; high if the round was a false start.
- `reaction_ms`  in  16  reaction time from the timer, in ms.
- `fsm_start`  out  1  one-cycle start pulse to the game FSM.
- `disp_number`  out  16  value for the seven-segment driver.
- `round_idx`  out  4  current round, 1..ROUNDS; 0 in IDLE.
- `best_ms`  out  16  minimum valid time; 16'hFFFF if there is none.
- `avg_ms`  out  16  floor(sum / valid_cnt); 16'hEEEE if valid_cnt = 0.
- `busy`  out  1  high in every state except IDLE and DONE.
- `session_done`  out  1  high in DONE.

## Operation
States: IDLE, START, WAIT_RES, HOLD, DIVIDE, DONE.

- **IDLE**
  - On `session_btn`: clear sum (24 bit), valid_cnt, early_cnt and hold counter.
  - Set best = 16'hFFFF and round_idx = 1, then go to START.
- **START**
  - `fsm_start` = 1 for exactly this one cycle, then go to WAIT_RES.
- **WAIT_RES**
  - Wait for a rising edge of `fsm_show_time`. The edge register updates every cycle in every state and resets to 0.
  - On the edge with `fsm_early_error` = 1: early_cnt++, last = 16'hEEEE.
  - Otherwise: sum += `reaction_ms` zero-extended to 24 bits, valid_cnt++, best = min(best, `reaction_ms`), last = `reaction_ms`.
  - Then go to HOLD with the hold counter at 0.
- **HOLD**
  - The hold counter increments on each `ms_tick`.
  - When it reaches HOLD_MS: if round_idx = ROUNDS, go to DIVIDE; otherwise round_idx++ and go to START.
- **DIVIDE**
  - Restoring division sum / valid_cnt, one quotient bit per cycle, 24 cycles.
  - If valid_cnt = 0, skip the division: set avg = 16'hEEEE and go to DONE on the next cycle.
  - The quotient is ≤ 16'hFFFF by construction; store its low 16 bits.
- **DONE**
  - `session_done` = 1; outputs hold.
  - `session_btn` starts a new session exactly as from IDLE.

Display (`disp_number`):
- IDLE: 16'h0000.
- START and WAIT_RES: 16'h0000.
- HOLD: last.
- DIVIDE: 16'h0000.
- DONE: `disp_sel` ? best : avg.

Boundary rules:
- `session_btn` is ignored while `busy` = 1.
- Edges of `fsm_show_time` outside WAIT_RES are ignored.
- A round with `reaction_ms` = 0 is valid.
- `rst` in any state returns to IDLE on the next edge and reinitialises everything.

## Timing
Values held while `rst` = 1:
- `fsm_start`, `busy`, `session_done`, `round_idx`: 0.
- `disp_number`: 0.
- `best_ms`: 16'hFFFF.
- `avg_ms`: 16'hEEEE.

Cycle-level behaviour:
- All outputs are registered.
- `fsm_start` goes high in the cycle after `session_btn` is sampled in IDLE or DONE.
- For later rounds, `fsm_start` goes high in the cycle after the final hold tick is sampled.
- Result capture happens in the cycle after `fsm_show_time` rises. `best_ms` and `disp_number` update on that same edge.
- HOLD exits on the clock edge after the HOLD_MS-th `ms_tick`. The hold duration is HOLD_MS ms ±1 ms.
- DIVIDE takes exactly 24 cycles, or 1 cycle if valid_cnt = 0.
- `avg_ms` and `session_done` update together on DIVIDE exit.
- `ms_tick` coinciding with a state transition is counted only while in HOLD.

## Test plan
- **All valid rounds.** ROUNDS = 5, HOLD_MS = 2. Valid times 200, 300, 250, 400, 350.
  - Exactly 5 `fsm_start` pulses.
  - `best_ms` = 200, `avg_ms` = 300 (16'h012C), `session_done` = 1.
- **Mixed false starts.** ROUNDS = 4. Rounds: early, 120, early, 181.
  - `disp_number` = 16'hEEEE during the first HOLD.
  - `best_ms` = 120, `avg_ms` = 150 (truncated).
- **All false starts.** ROUNDS = 3, every round early.
  - `best_ms` = 16'hFFFF, `avg_ms` = 16'hEEEE.
  - DONE is reached one cycle after the last HOLD.
- **Large values.** ROUNDS = 2, times 65535 and 65534.
  - `avg_ms` = 65534, no overflow; DIVIDE lasts 24 cycles.
- **Button and stray-edge handling.** `session_btn` pulsed in WAIT_RES and in HOLD.
  - No restart, no extra `fsm_start`.
  - A stray `fsm_show_time` edge during HOLD does not change sum or valid_cnt.
- **Reset mid-operation.** `rst` asserted mid-HOLD in round 3.
  - Next cycle: IDLE, `round_idx` = 0, `best_ms` = 16'hFFFF, `fsm_start` = 0.
  - A new `session_btn` yields a fresh 5-round session.

Source files
------------

// File: rtl/reaction_session_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_session_ctrl
//
// Multi-round session scheduler for the reaction game. It issues one start
// pulse per round to the single-round game FSM and captures each round result
// from the reaction-timer datapath. It tracks the best valid time and, after
// the last round, the truncated average of the valid rounds. It also selects
// the number shown on the seven-segment driver.
//
// Parameters
//   ROUNDS   rounds per session (1..15)
//   HOLD_MS  ms each round result stays on display (1..65535)
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   ms_tick          one-cycle pulse every 1 ms
//   session_btn      one-cycle debounced pulse, starts a session
//   disp_sel         DONE display select: 0 = average, 1 = best
//   fsm_show_time    game FSM level, high while a round result is valid
//   fsm_early_error  game FSM level, high if the round was a false start
//   reaction_ms      reaction time from the timer, in ms
//   fsm_start        one-cycle start pulse to the game FSM
//   disp_number      value for the seven-segment driver
//   round_idx        current round 1..ROUNDS, 0 in IDLE
//   best_ms          minimum valid time, 16'hFFFF if none
//   avg_ms           floor(sum / valid_cnt), 16'hEEEE if no valid round
//   busy             high in every state except IDLE and DONE
//   session_done     high in DONE
// -----------------------------------------------------------------------------
module reaction_session_ctrl #(
  parameter int ROUNDS  = 5,
  parameter int HOLD_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  input  logic        session_btn,
  input  logic        disp_sel,
  input  logic        fsm_show_time,
  input  logic        fsm_early_error,
  input  logic [15:0] reaction_ms,
  output logic        fsm_start,
  output logic [15:0] disp_number,
  output logic [3:0]  round_idx,
  output logic [15:0] best_ms,
  output logic [15:0] avg_ms,
  output logic        busy,
  output logic        session_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DIVIDE   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [3:0]  ROUNDS_LAST = 4'(ROUNDS);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_MS - 1);
  localparam logic [4:0]  DIV_LAST    = 5'd23;
  localparam logic [15:0] NO_BEST     = 16'hFFFF;
  localparam logic [15:0] NO_AVG      = 16'hEEEE;

  state_t      state_r, state_nxt_s;
  logic        show_d_r;
  logic        show_rise_s;

  logic [23:0] sum_r, sum_nxt_s;
  logic [3:0]  valid_cnt_r, valid_cnt_nxt_s;
  logic [3:0]  early_cnt_r, early_cnt_nxt_s;
  logic [3:0]  round_r, round_nxt_s;
  logic [15:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [15:0] best_r, best_nxt_s;
  logic [15:0] avg_r, avg_nxt_s;
  logic [15:0] last_r, last_nxt_s;

  // Restoring divider: quo_r starts as the dividend and shifts quotient bits
  // in from the right; the remainder never exceeds the 4-bit divisor.
  logic [23:0] quo_r, quo_nxt_s;
  logic [3:0]  rem_r, rem_nxt_s;
  logic [4:0]  div_cnt_r, div_cnt_nxt_s;
  logic [4:0]  partial_s;
  logic        take_s;
  logic [3:0]  diff_s;
  logic [23:0] quo_step_s;
  logic [3:0]  rem_step_s;

  logic        hold_done_s;
  logic        last_round_s;
  logic        div_done_s;

  logic        fsm_start_r, fsm_start_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic [15:0] disp_r, disp_nxt_s;

  assign show_rise_s  = fsm_show_time & ~show_d_r;
  assign hold_done_s  = ms_tick & (hold_cnt_r == HOLD_LAST);
  assign last_round_s = (round_r == ROUNDS_LAST);
  assign div_done_s   = (div_cnt_r == DIV_LAST);

  assign partial_s  = {rem_r, quo_r[23]};
  assign take_s     = (partial_s >= {1'b0, valid_cnt_r});
  // When take_s is set the true difference is below 16, so 4 bits suffice.
  assign diff_s     = partial_s[3:0] - valid_cnt_r;
  assign rem_step_s = take_s ? diff_s : partial_s[3:0];
  assign quo_step_s = {quo_r[22:0], take_s};

  assign fsm_start    = fsm_start_r;
  assign busy         = busy_r;
  assign session_done = done_r;
  assign disp_number  = disp_r;
  assign round_idx    = round_r;
  assign best_ms      = best_r;
  assign avg_ms       = avg_r;

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      show_d_r    <= 1'b0;
      sum_r       <= 24'd0;
      valid_cnt_r <= 4'd0;
      early_cnt_r <= 4'd0;
      round_r     <= 4'd0;
      hold_cnt_r  <= 16'd0;
      best_r      <= NO_BEST;
      avg_r       <= NO_AVG;
      last_r      <= 16'd0;
      quo_r       <= 24'd0;
      rem_r       <= 4'd0;
      div_cnt_r   <= 5'd0;
      fsm_start_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      disp_r      <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      show_d_r    <= fsm_show_time;
      sum_r       <= sum_nxt_s;
      valid_cnt_r <= valid_cnt_nxt_s;
      early_cnt_r <= early_cnt_nxt_s;
      round_r     <= round_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      best_r      <= best_nxt_s;
      avg_r       <= avg_nxt_s;
      last_r      <= last_nxt_s;
      quo_r       <= quo_nxt_s;
      rem_r       <= rem_nxt_s;
      div_cnt_r   <= div_cnt_nxt_s;
      fsm_start_r <= fsm_start_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      disp_r      <= disp_nxt_s;
    end
  end

  // Next-state logic of the session sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (session_btn) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (show_rise_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT_RES;
        end
      end
      ST_HOLD: begin
        if (hold_done_s) begin
          if (last_round_s) begin
            state_nxt_s = ST_DIVIDE;
          end else begin
            state_nxt_s = ST_START;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DIVIDE: begin
        if ((valid_cnt_r == 4'd0) || div_done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DIVIDE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: session clear, result capture, hold timing, division.
  always_comb begin
    sum_nxt_s       = sum_r;
    valid_cnt_nxt_s = valid_cnt_r;
    early_cnt_nxt_s = early_cnt_r;
    round_nxt_s     = round_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    best_nxt_s      = best_r;
    avg_nxt_s       = avg_r;
    last_nxt_s      = last_r;
    quo_nxt_s       = quo_r;
    rem_nxt_s       = rem_r;
    div_cnt_nxt_s   = div_cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (session_btn) begin
          sum_nxt_s       = 24'd0;
          valid_cnt_nxt_s = 4'd0;
          early_cnt_nxt_s = 4'd0;
          hold_cnt_nxt_s  = 16'd0;
          best_nxt_s      = NO_BEST;
          round_nxt_s     = 4'd1;
        end else begin
          round_nxt_s = round_r;
        end
      end
      ST_START: begin
        hold_cnt_nxt_s = 16'd0;
      end
      ST_WAIT_RES: begin
        hold_cnt_nxt_s = 16'd0;
        if (show_rise_s) begin
          if (fsm_early_error) begin
            early_cnt_nxt_s = early_cnt_r + 4'd1;
            last_nxt_s      = NO_AVG;
          end else begin
            sum_nxt_s       = sum_r + {8'd0, reaction_ms};
            valid_cnt_nxt_s = valid_cnt_r + 4'd1;
            best_nxt_s      = (reaction_ms < best_r) ? reaction_ms : best_r;
            last_nxt_s      = reaction_ms;
          end
        end else begin
          last_nxt_s = last_r;
        end
      end
      ST_HOLD: begin
        if (ms_tick) begin
          hold_cnt_nxt_s = hold_cnt_r + 16'd1;
          if (hold_done_s) begin
            if (last_round_s) begin
              // Load the divider on the way into DIVIDE.
              quo_nxt_s     = sum_r;
              rem_nxt_s     = 4'd0;
              div_cnt_nxt_s = 5'd0;
            end else begin
              round_nxt_s = round_r + 4'd1;
            end
          end else begin
            round_nxt_s = round_r;
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r;
        end
      end
      ST_DIVIDE: begin
        if (valid_cnt_r == 4'd0) begin
          avg_nxt_s = NO_AVG;
        end else begin
          quo_nxt_s     = quo_step_s;
          rem_nxt_s     = rem_step_s;
          div_cnt_nxt_s = div_cnt_r + 5'd1;
          // Sum of at most 15 16-bit values over the count fits in 16 bits.
          if (div_done_s) begin
            avg_nxt_s = quo_step_s[15:0];
          end else begin
            avg_nxt_s = avg_r;
          end
        end
      end
      default: begin
        round_nxt_s = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so that every output is registered.
  always_comb begin
    fsm_start_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    done_nxt_s      = 1'b0;
    disp_nxt_s      = 16'd0;
    case (state_nxt_s)
      ST_IDLE: begin
        disp_nxt_s = 16'd0;
      end
      ST_START: begin
        fsm_start_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      ST_WAIT_RES, ST_DIVIDE: begin
        busy_nxt_s = 1'b1;
      end
      ST_HOLD: begin
        busy_nxt_s = 1'b1;
        disp_nxt_s = last_nxt_s;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
        disp_nxt_s = disp_sel ? best_nxt_s : avg_nxt_s;
      end
      default: begin
        disp_nxt_s = 16'd0;
      end
    endcase
  end

endmodule
